am2929_busarb: RTL and testbench
================================

Name: am2929_busarb

Overview:
- Round-robin arbiter and sequencer for one shared inverting tristate bus built from NREQ am2929-style transceiver slices.
- Grants bus drive to exactly one requester at a time by controlling each slice's BE (drive enable, active-high) and RE_ (receive enable, active-low).
- Inserts turnaround cycles between owners so two slices never drive simultaneously.
- Enforces a maximum hold time when other ports are waiting.

Parameters:
- NREQ, 4, number of requester ports / transceiver slices (2..8).
- IDW, 2, width of owner index output; must satisfy 2**IDW >= NREQ.
- MAXHOLD, 8, max cycles one owner may hold while another request is pending; 0 = unlimited.
- TURN_CYC, 1, idle turnaround cycles (all BE low) after each release; 1..15.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- req  input  NREQ  bus request per port; level, held high for the whole transfer.
- lsn  input  NREQ  port wants to receive bus data.
- be  output  NREQ  drive enable to slice i, active-high, one-hot or zero.
- re_  output  NREQ  receive enable to slice i, active-low.
- gnt  output  NREQ  grant to requester, equal to be.
- own  output  IDW  index of current owner; valid when busy_drv=1, else 0.
- busy_drv  output  1  a port currently drives the bus.
- busy  output  1  state != IDLE.

Behaviour:
- Reset (async, immediate, any state including mid-transfer): state=IDLE, be=gnt=0, re_=all 1, own=0, busy=busy_drv=0, rr pointer=0, hold counter=0, turn counter=0.
- All outputs are registered.
- State IDLE:
  - If req=0, remain in IDLE.
  - Otherwise pick the first set req bit scanning upward from the rr pointer, wrapping at NREQ-1 to 0.
  - Go to GRANT; be/gnt one-hot at the winner; own=winner.
  - Latency: req sampled at edge k, gnt high after edge k.
- State GRANT:
  - Hold counter increments each cycle, saturating at MAXHOLD.
  - Release when req[own]=0, OR when MAXHOLD!=0, the counter has reached MAXHOLD-1, and (req & ~gnt)!=0.
  - On release: go to TURN (or IDLE if TURN_CYC=0 is ever allowed; it is not); be=gnt=0; busy_drv=0; rr pointer=(own+1) mod NREQ; hold counter cleared.
  - Without release, stay in GRANT; be unchanged.
  - A req change on non-owner ports has no effect on the current grant.
- State TURN:
  - Turn counter runs TURN_CYC cycles with be=0.
  - On the last TURN cycle, if req!=0, arbitrate as in IDLE and enter GRANT directly; else go to IDLE.
  - The just-released owner is eligible again but has lowest priority.
  - A timed-out owner that still holds req re-enters arbitration normally.
- Drive exclusivity invariant: popcount(be)<=1 every cycle. Between any falling be[i] and rising be[j] there are >= TURN_CYC cycles with be=0, including i==j.
- re_[i] (registered) = ~(lsn[i] & ~be_next[i]):
  - A listening port receives in every state, including TURN and IDLE.
  - The owner's receiver is always disabled.
- Simultaneous events:
  - req[own] drops in the same cycle a timeout fires: a single release, same result.
  - Multiple new reqs arriving in IDLE: round-robin order from the pointer.
- own is held at the last owner's value while busy_drv=0? No: own=0 whenever busy_drv=0.

Test Plan:
- Reset mid-GRANT: assert rst while port 2 owns → be=0, re_=4'b1111, own=0, busy=0 immediately, without waiting for clk. After release, req=4'b0001 → gnt=4'b0001 one clk later.
- Single requester: req=4'b0100 for 5 cycles, then 0 → be=4'b0100 for 5 cycles, own=2. TURN for 1 cycle, then IDLE, busy=0. The pointer is now 3.
- Round-robin: from pointer 0, req=4'b1011 constantly, MAXHOLD=8 → grant order 0,1,3,0 with 8-cycle holds. Each hold is separated by exactly 1 be=0 cycle.
- Timeout versus lone owner: req=4'b0001 for 20 cycles, with no other req → port 0 holds all 20 cycles. Raise req[1] at cycle 5 → port 0 is released at hold count 8, then TURN, then gnt=4'b0010.
- Receive enables: lsn=4'b1111 while port 1 owns → re_=4'b0010. During TURN → re_=4'b0000. With lsn=0 → re_=4'b1111.
- TURN_CYC=3, NREQ=8: back-to-back owners 5 then 6 → exactly 3 cycles of be=0 between them. popcount(be)<=1 is asserted throughout a random req/lsn run of 10k cycles.

Source files
------------

// File: rtl/am2929_busarb.sv
// Round-robin arbiter/sequencer for a shared inverting tristate bus of am2929-style slices.
// Latency: req sampled at edge k gives be/gnt after edge k; every output is registered.
// Backpressure: requesters hold req until granted; an owner is cut off after MAXHOLD cycles if others wait.
module am2929_busarb #(
   parameter int NREQ     = 4,
   parameter int IDW      = 2,
   parameter int MAXHOLD  = 8,
   parameter int TURN_CYC = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NREQ-1:0] req,
   input  logic [NREQ-1:0] lsn,
   output logic [NREQ-1:0] be,
   output logic [NREQ-1:0] re_,
   output logic [NREQ-1:0] gnt,
   output logic [IDW-1:0]  own,
   output logic            busy_drv,
   output logic            busy
);

   // Hold counter must be able to reach MAXHOLD (it saturates there).
   localparam int HW = (MAXHOLD < 2) ? 1 : $clog2(MAXHOLD + 1);
   // Turnaround is limited to 15 cycles, so 4 bits always suffice.
   localparam int TW = 4;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_GRANT = 2'd1;
   localparam logic [1:0] ST_TURN  = 2'd2;

   logic [1:0]      state_q,    state_d;
   logic [NREQ-1:0] be_q,       be_d;
   logic [NREQ-1:0] re_q,       re_d;
   logic [IDW-1:0]  own_q,      own_d;
   logic            busy_q,     busy_d;
   logic            busy_drv_q, busy_drv_d;
   logic [IDW-1:0]  ptr_q,      ptr_d;
   logic [HW-1:0]   hold_q,     hold_d;
   logic [TW-1:0]   turn_q,     turn_d;

   // Arbitration helpers
   logic [2*NREQ-1:0] req_dbl;
   logic [NREQ-1:0]   req_rot;
   logic              arb_hit;
   logic [IDW-1:0]    arb_win;
   logic              owner_req;
   logic              pending_other;
   logic              hold_expired;
   logic              release_now;
   logic              turn_last;
   logic [IDW-1:0]    ptr_after_own;

   // Round-robin pick: rotate req so the pointer lands at bit 0, take the first set bit.
   always_comb begin
      req_dbl = {req, req} >> ptr_q;
      req_rot = req_dbl[NREQ-1:0];
      arb_hit = 1'b0;
      arb_win = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (!arb_hit && req_rot[i]) begin
            arb_hit = 1'b1;
            arb_win = IDW'((int'(ptr_q) + i) % NREQ);
         end
      end
   end

   // Release conditions for the current owner and turnaround end detection.
   always_comb begin
      owner_req     = |(req & be_q);
      pending_other = |(req & ~be_q);
      // ">=" rather than "==": the counter saturates at MAXHOLD, so a request that
      // shows up after a long lone hold must still be able to force a release.
      hold_expired  = (MAXHOLD != 0) && (int'(hold_q) >= MAXHOLD - 1);
      release_now   = !owner_req || (hold_expired && pending_other);
      turn_last     = (int'(turn_q) >= TURN_CYC - 1);
      ptr_after_own = (int'(own_q) == NREQ - 1) ? '0 : own_q + IDW'(1);
   end

   // Next-state logic for the IDLE / GRANT / TURN sequencer.
   always_comb begin
      state_d = state_q;
      be_d    = be_q;
      own_d   = own_q;
      ptr_d   = ptr_q;
      hold_d  = hold_q;
      turn_d  = turn_q;

      case (state_q)
         ST_IDLE: begin
            if (arb_hit) begin
               state_d = ST_GRANT;
               be_d    = NREQ'(1) << arb_win;
               own_d   = arb_win;
               hold_d  = '0;
            end
         end

         ST_GRANT: begin
            if (release_now) begin
               // A dropped req and an expired hold in the same cycle collapse into one release.
               state_d = ST_TURN;
               be_d    = '0;
               own_d   = '0;
               ptr_d   = ptr_after_own;
               hold_d  = '0;
               turn_d  = '0;
            end else if (int'(hold_q) < MAXHOLD) begin
               hold_d = hold_q + HW'(1);
            end
         end

         ST_TURN: begin
            if (turn_last) begin
               turn_d = '0;
               if (arb_hit) begin
                  // The pointer already moved past the old owner, so it ranks last here.
                  state_d = ST_GRANT;
                  be_d    = NREQ'(1) << arb_win;
                  own_d   = arb_win;
                  hold_d  = '0;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               turn_d = turn_q + TW'(1);
            end
         end

         default: begin
            state_d = ST_IDLE;
            be_d    = '0;
            own_d   = '0;
            hold_d  = '0;
            turn_d  = '0;
         end
      endcase
   end

   // Derived outputs computed from next-state values so they can be registered too.
   always_comb begin
      busy_drv_d = |be_d;
      busy_d     = (state_d != ST_IDLE);
      // Listening ports receive in every state; the driving slice never receives.
      re_d       = ~(lsn & ~be_d);
   end

   // State and output registers with immediate asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         be_q       <= '0;
         re_q       <= '1;
         own_q      <= '0;
         busy_q     <= 1'b0;
         busy_drv_q <= 1'b0;
         ptr_q      <= '0;
         hold_q     <= '0;
         turn_q     <= '0;
      end else begin
         state_q    <= state_d;
         be_q       <= be_d;
         re_q       <= re_d;
         own_q      <= own_d;
         busy_q     <= busy_d;
         busy_drv_q <= busy_drv_d;
         ptr_q      <= ptr_d;
         hold_q     <= hold_d;
         turn_q     <= turn_d;
      end
   end

   assign be       = be_q;
   assign gnt      = be_q;
   assign re_      = re_q;
   assign own      = own_q;
   assign busy     = busy_q;
   assign busy_drv = busy_drv_q;

endmodule

// File: tb/tb_am2929_busarb.sv
// Directed bench for am2929_busarb: a 4-port instance with one turnaround cycle
// and an 8-port instance with three turnaround cycles plus a random exclusivity run.
module tb_am2929_busarb;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic [3:0] req, lsn;
   logic [3:0] be, re_n, gnt;
   logic [1:0] own;
   logic       busy_drv, busy;

   logic [7:0] req8, lsn8;
   logic [7:0] be8, re8, gnt8;
   logic [2:0] own8;
   logic       busy_drv8, busy8;

   am2929_busarb #(.NREQ(4), .IDW(2), .MAXHOLD(8), .TURN_CYC(1)) u_dut4 (
      .clk(clk), .rst(rst), .req(req), .lsn(lsn), .be(be), .re_(re_n),
      .gnt(gnt), .own(own), .busy_drv(busy_drv), .busy(busy)
   );

   am2929_busarb #(.NREQ(8), .IDW(3), .MAXHOLD(8), .TURN_CYC(3)) u_dut8 (
      .clk(clk), .rst(rst), .req(req8), .lsn(lsn8), .be(be8), .re_(re8),
      .gnt(gnt8), .own(own8), .busy_drv(busy_drv8), .busy(busy8)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int         order [4];
      logic [7:0] prev_be;
      logic [7:0] lp;
      logic [7:0] re_exp;
      int         zrun;
      bit         seen_fall;

      rst = 1'b1; req = '0; lsn = '0; req8 = '0; lsn8 = '0;
      step(); step();

      // Reset state
      chk("rst_be",       32'(be),        0);
      chk("rst_gnt",      32'(gnt),       0);
      chk("rst_re",       32'(re_n),      'hF);
      chk("rst_own",      32'(own),       0);
      chk("rst_busy",     32'(busy),      0);
      chk("rst_busy_drv", 32'(busy_drv),  0);
      chk("rst_be8",      32'(be8),       0);
      chk("rst_re8",      32'(re8),       'hFF);

      rst = 1'b0;
      step();

      // Reset in the middle of a grant to port 2 acts without a clock edge
      req = 4'b0100;
      step();
      chk("a_be",   32'(be),   'b0100);
      chk("a_own",  32'(own),  2);
      chk("a_busy", 32'(busy), 1);
      #2 rst = 1'b1;
      #1;
      chk("a_async_be",       32'(be),       0);
      chk("a_async_re",       32'(re_n),     'hF);
      chk("a_async_own",      32'(own),      0);
      chk("a_async_busy",     32'(busy),     0);
      chk("a_async_busy_drv", 32'(busy_drv), 0);
      req = '0;
      step();
      rst = 1'b0;
      step();
      req = 4'b0001;
      step();
      chk("a_regrant", 32'(gnt), 'b0001);
      req = '0;
      step();
      chk("a_rel_be",   32'(be),   0);
      chk("a_rel_busy", 32'(busy), 1);
      step();
      chk("a_idle", 32'(busy), 0);

      // Single requester on port 2: five cycles of drive, one turnaround, idle
      req = 4'b0100;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("b_be",  32'(be),  'b0100);
         chk("b_own", 32'(own), 2);
      end
      req = '0;
      step();
      chk("b_turn_be",   32'(be),       0);
      chk("b_turn_drv",  32'(busy_drv), 0);
      chk("b_turn_own",  32'(own),      0);
      chk("b_turn_busy", 32'(busy),     1);
      step();
      chk("b_idle_busy", 32'(busy), 0);
      // Pointer is 3 now: all-ones request must go to port 3
      req = 4'b1111;
      step();
      chk("b_ptr3_be",  32'(be),  'b1000);
      chk("b_ptr3_own", 32'(own), 3);
      req = '0;
      step(); step();

      // Round-robin from pointer 0 with 8-cycle holds and single-cycle gaps
      order[0] = 0; order[1] = 1; order[2] = 3; order[3] = 0;
      req = 4'b1011;
      for (int k = 0; k < 4; k++) begin
         for (int c = 0; c < 8; c++) begin
            step();
            chk("c_hold", 32'(be), 1 << order[k]);
         end
         if (k < 3) begin
            step();
            chk("c_gap", 32'(be), 0);
         end
      end
      req = '0;
      step();
      chk("c_end_be", 32'(be), 0);
      step();

      // Lone owner is never cut off
      req = 4'b0001;
      for (int i = 0; i < 20; i++) begin
         step();
         chk("d_lone", 32'(be), 'b0001);
      end
      req = '0;
      step();
      chk("d_lone_rel", 32'(be), 0);
      step();

      // Competing request from cycle 5 forces release after 8 cycles
      req = 4'b0001;
      for (int n = 1; n <= 8; n++) begin
         step();
         chk("d_hold", 32'(be), 'b0001);
         if (n == 5) req = 4'b0011;
      end
      step();
      chk("d_timeout_turn", 32'(be), 0);
      step();
      chk("d_next_gnt", 32'(gnt), 'b0010);
      chk("d_next_own", 32'(own), 1);

      // Receive enables while port 1 owns, in turnaround, in idle
      lsn = 4'b1111;
      step();
      chk("e_own_re", 32'(re_n), 'b0010);
      chk("e_own_be", 32'(be),   'b0010);
      req = '0;
      step();
      chk("e_turn_re",   32'(re_n), 0);
      chk("e_turn_busy", 32'(busy), 1);
      step();
      chk("e_idle_re",   32'(re_n), 0);
      chk("e_idle_busy", 32'(busy), 0);
      lsn = 4'b0101;
      step();
      chk("e_part_re", 32'(re_n), 'b1010);
      lsn = '0;
      step();
      chk("e_none_re", 32'(re_n), 'hF);

      // 8 ports, 3 turnaround cycles: owner 5 then owner 6
      req8 = 8'h60;
      step();
      chk("f_be5",  32'(be8),  'h20);
      chk("f_own5", 32'(own8), 5);
      step();
      chk("f_be5b", 32'(be8),  'h20);
      req8 = 8'h40;
      for (int t = 0; t < 3; t++) begin
         step();
         chk("f_turn", 32'(be8), 0);
      end
      step();
      chk("f_be6",  32'(be8),  'h40);
      chk("f_own6", 32'(own8), 6);
      req8 = '0;
      for (int t = 0; t < 4; t++) step();
      chk("f_idle", 32'(busy8), 0);

      // Random request/listen traffic on the 8-port instance
      prev_be   = be8;
      zrun      = 0;
      seen_fall = 1'b0;
      for (int i = 0; i < 10000; i++) begin
         if ($urandom_range(0, 3) == 0) req8 = 8'($urandom);
         lsn8 = 8'($urandom);
         lp   = lsn8;
         step();
         chk("r_pop", 32'($countones(be8) <= 1), 1);
         chk("r_gnt", 32'(gnt8), 32'(be8));
         chk("r_drv", 32'(busy_drv8), 32'(be8 != 0));
         re_exp = ~(lp & ~be8);
         chk("r_re", 32'(re8), 32'(re_exp));
         if (be8 != 0) chk("r_own", 32'(be8), 1 << own8);
         else          chk("r_own0", 32'(own8), 0);
         if (prev_be != 0 && be8 != 0) chk("r_noswap", 32'(be8), 32'(prev_be));
         if (prev_be == 0 && be8 != 0 && seen_fall) chk("r_gap", 32'(zrun >= 3), 1);
         if (prev_be != 0 && be8 == 0) seen_fall = 1'b1;
         if (be8 == 0) zrun++;
         else          zrun = 0;
         prev_be = be8;
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
